// File: rtl/gate_op_pkg.sv
// Shared types for the gate-op arbiter: opcode encoding and sequencer states.
package gate_op_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND   = 3'd0;
    localparam op_t OP_OR    = 3'd1;
    localparam op_t OP_NAND  = 3'd2;
    localparam op_t OP_NOR   = 3'd3;
    localparam op_t OP_NOT_A = 3'd4;
    localparam op_t OP_NOT_B = 3'd5;
    localparam op_t OP_XOR   = 3'd6;
    localparam op_t OP_XNOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between the client blocks and the gate-op arbiter.
interface gate_op_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    // Client / consumer side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/gate_alu.sv
// Purely combinational bitwise two-input logic unit shared by all requesters.
module gate_alu
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Apply the selected gate across every bit of the operands
    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_NOT_A: result = ~a;
            OP_NOT_B: result = ~b;
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter/sequencer sharing one gate_alu among NREQ requesters.
// One operation is in flight at a time: IDLE grants, EXEC computes, RESP
// holds the tagged result until the consumer takes it.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    gate_op_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             busy_q, busy_d;

    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [IDW-1:0]   cand_s;
    logic [NREQ-1:0]  req_ready_s;
    logic [WIDTH-1:0] alu_result_s;

    gate_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result_s)
    );

    // Round-robin search: first valid requester at or above rr_ptr, wrapping
    // (NREQ is a power of two, so the IDW-bit add wraps naturally)
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = rr_ptr_q + IDW'(i);
            if (!grant_found_s && bus.req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Sequencer next-state, operand latching and response register updates
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    op_d     = bus.req_op[3*int'(grant_idx_s) +: 3];
                    a_d      = bus.req_a[WIDTH*int'(grant_idx_s) +: WIDTH];
                    b_d      = bus.req_b[WIDTH*int'(grant_idx_s) +: WIDTH];
                    id_d     = grant_idx_s;
                    rr_ptr_d = grant_idx_s + IDW'(1'b1);
                    state_d  = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result_s;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer, operand and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: directed stimulus pushes expected
// grants/responses; a negedge monitor pops and compares.
module tb_gate_op_arbiter;
    import gate_op_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_op_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) vif ();

    gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int grants_seen = 0;
    bit chk_gap = 1'b0;
    bit chk_after_accept = 1'b0;

    logic [1:0] exp_grant_q[$];
    logic [9:0] exp_rsp_q[$];

    // a=F0, b=CC through opcodes 0..7
    logic [7:0] exp_tab [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h0F, 8'h33, 8'h3C, 8'hC3};

    // free-running cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Present a request on requester i, hold it until granted, then drop it
    task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int k;
        bit got;
        vif.req_op[3*i +: 3]     = op;
        vif.req_a[WIDTH*i +: WIDTH] = a;
        vif.req_b[WIDTH*i +: WIDTH] = b;
        vif.req_valid[i]         = 1'b1;
        got = 1'b0;
        for (k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (vif.req_ready[i]) got = 1'b1;
        end
        if (!got) timeout("issue_grant");
        @(posedge clk);
        #1;
        vif.req_valid[i] = 1'b0;
    endtask

    // Wait until every expected event has been seen and the block is idle
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            #1;
            if (exp_grant_q.size() == 0 && exp_rsp_q.size() == 0 && !vif.busy) done = 1'b1;
        end
        if (!done) timeout(name);
    endtask

    // Monitor: grants, response latency, stability under backpressure, data
    initial begin : monitor
        int last_grant;
        int acc_cyc;
        bit have_grant;
        bit have_acc;
        bit prev_valid;
        bit prev_acc;
        logic [7:0] prev_data;
        logic [1:0] prev_id;
        logic [1:0] eg;
        logic [9:0] er;
        last_grant = 0; acc_cyc = 0; have_grant = 1'b0; have_acc = 1'b0;
        prev_valid = 1'b0; prev_acc = 1'b0; prev_data = 8'h00; prev_id = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_grant = 1'b0;
                have_acc   = 1'b0;
                prev_valid = 1'b0;
                prev_acc   = 1'b0;
            end else begin
                if (vif.req_ready != 4'b0000) begin
                    if (exp_grant_q.size() == 0) begin
                        check("unexpected_grant", 32'(vif.req_ready), 32'd0);
                    end else begin
                        eg = exp_grant_q.pop_front();
                        check("grant_vec", 32'(vif.req_ready), 32'd1 << eg);
                    end
                    if (chk_gap && have_grant) check("grant_gap", 32'(cyc - last_grant), 32'd3);
                    if (chk_after_accept && have_acc) check("grant_after_accept", 32'(cyc - acc_cyc), 32'd1);
                    last_grant = cyc;
                    have_grant = 1'b1;
                    grants_seen++;
                end
                if (vif.rsp_valid) begin
                    if (!prev_valid) begin
                        if (have_grant) check("rsp_latency", 32'(cyc - last_grant), 32'd2);
                    end else if (!prev_acc) begin
                        check("hold_data", 32'(vif.rsp_data), 32'(prev_data));
                        check("hold_id", 32'(vif.rsp_id), 32'(prev_id));
                        check("ready_in_resp", 32'(vif.req_ready), 32'd0);
                    end
                    if (vif.rsp_ready) begin
                        if (exp_rsp_q.size() == 0) begin
                            check("unexpected_rsp", 32'(vif.rsp_valid), 32'd0);
                        end else begin
                            er = exp_rsp_q.pop_front();
                            check("rsp_id", 32'(vif.rsp_id), 32'(er[9:8]));
                            check("rsp_data", 32'(vif.rsp_data), 32'(er[7:0]));
                        end
                        acc_cyc  = cyc;
                        have_acc = 1'b1;
                    end
                end
                prev_valid = vif.rsp_valid;
                prev_acc   = vif.rsp_valid && vif.rsp_ready;
                prev_data  = vif.rsp_data;
                prev_id    = vif.rsp_id;
            end
        end
    end

    // Directed stimulus
    initial begin : stim
        int target;
        bit got;
        rst           = 1'b1;
        vif.req_valid = '0;
        vif.req_op    = '0;
        vif.req_a     = '0;
        vif.req_b     = '0;
        vif.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_rsp_valid", 32'(vif.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(vif.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(vif.rsp_id), 32'd0);
        check("rst_busy", 32'(vif.busy), 32'd0);
        check("rst_req_ready", 32'(vif.req_ready), 32'd0);

        // single request from requester 2
        exp_grant_q.push_back(2'd2);
        exp_rsp_q.push_back({2'd2, 8'hC0});
        issue(2, OP_AND, 8'hF0, 8'hCC);
        drain("drain_single");

        // opcode sweep on requester 1
        for (int op = 0; op < 8; op++) begin
            exp_grant_q.push_back(2'd1);
            exp_rsp_q.push_back({2'd1, exp_tab[op]});
            issue(1, 3'(op), 8'hF0, 8'hCC);
            drain("drain_sweep");
        end

        // contention: all four valid from reset, op i on requester i
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            vif.req_op[3*i +: 3]        = 3'(i);
            vif.req_a[WIDTH*i +: WIDTH] = 8'hF0;
            vif.req_b[WIDTH*i +: WIDTH] = 8'hCC;
        end
        vif.req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            exp_grant_q.push_back(2'(g % 4));
            exp_rsp_q.push_back({2'(g % 4), exp_tab[g % 4]});
        end
        chk_gap = 1'b1;
        target  = grants_seen + 6;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            if (grants_seen >= target) got = 1'b1;
        end
        if (!got) timeout("contention_grants");
        #1;
        vif.req_valid = '0;
        drain("drain_contention");
        chk_gap = 1'b0;

        // pointer wrap: move rr_ptr to 3, then 1 and 3 together
        exp_grant_q.push_back(2'd2);
        exp_rsp_q.push_back({2'd2, 8'hFC});
        issue(2, OP_OR, 8'hF0, 8'hCC);
        drain("drain_ptr_setup");
        exp_grant_q.push_back(2'd3);
        exp_grant_q.push_back(2'd1);
        exp_rsp_q.push_back({2'd3, 8'h3F});
        exp_rsp_q.push_back({2'd1, 8'h33});
        fork
            issue(3, OP_NAND, 8'hF0, 8'hCC);
            issue(1, OP_NOT_B, 8'hF0, 8'hCC);
        join
        drain("drain_wrap");

        // backpressure: 5 cycles of rsp_ready low, requester 2 waiting
        vif.rsp_ready = 1'b0;
        exp_grant_q.push_back(2'd0);
        exp_grant_q.push_back(2'd2);
        exp_rsp_q.push_back({2'd0, 8'h55});
        exp_rsp_q.push_back({2'd2, 8'h5F});
        issue(0, OP_XOR, 8'h5A, 8'h0F);
        chk_after_accept = 1'b1;
        fork
            issue(2, OP_OR, 8'h5A, 8'h0F);
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    if (vif.rsp_valid) seen = 1'b1;
                end
                if (!seen) timeout("bp_rsp_valid");
                repeat (5) @(posedge clk);
                #1;
                vif.rsp_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk_after_accept = 1'b0;

        // reset while requester 3's op is in EXEC
        exp_grant_q.push_back(2'd3);
        exp_grant_q.push_back(2'd1);
        exp_rsp_q.push_back({2'd1, 8'h5A});
        vif.req_op[3*3 +: 3]        = OP_AND;
        vif.req_a[WIDTH*3 +: WIDTH] = 8'hFF;
        vif.req_b[WIDTH*3 +: WIDTH] = 8'hFF;
        vif.req_op[3*1 +: 3]        = OP_XNOR;
        vif.req_a[WIDTH*1 +: WIDTH] = 8'hAA;
        vif.req_b[WIDTH*1 +: WIDTH] = 8'h0F;
        vif.req_valid = 4'b1010;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (vif.req_ready[3]) got = 1'b1;
        end
        if (!got) timeout("abort_grant");
        @(posedge clk);
        #1;
        check("busy_exec", 32'(vif.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(vif.busy), 32'd0);
        check("abort_rsp_valid", 32'(vif.rsp_valid), 32'd0);
        check("abort_regrant", 32'(vif.req_ready), 32'd2);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (vif.req_ready[1]) got = 1'b1;
        end
        if (!got) timeout("abort_next_grant");
        @(posedge clk);
        #1;
        vif.req_valid = '0;
        drain("drain_abort");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_op_arbiter.md
# gate_op_arbiter

Round-robin arbiter and sequencer that shares one bitwise two-input logic unit among `NREQ` requesters. The unit computes AND, OR, NAND, NOR, NOT-A, NOT-B, XOR and XNOR.
- Each requester presents an opcode and two `WIDTH`-bit operands through a valid/ready handshake.
- The block grants one requester at a time, registers the operands, drives the shared unit, and returns a tagged result through a valid/ready response port.
- It sits between several client blocks and the single logic datapath.

## Interface
- `NREQ`, 4: number of requesters; must be a power of two, at least 2.
- `WIDTH`, 8: operand and result width in bits.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i set: requester i presents a request.
- `req_ready`  out  NREQ  bit i set: requester i's request is accepted this cycle.
- `req_op`  in  3*NREQ  opcode of requester i, in bits [3i+2:3i].
- `req_a`  in  WIDTH*NREQ  operand A of requester i, in slice i.
- `req_b`  in  WIDTH*NREQ  operand B of requester i, in slice i.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  WIDTH  result.
- `rsp_id`  out  log2(NREQ)  index of the requester that issued the operation.
- `busy`  out  1  high in EXEC and RESP.

## Operation
- Opcodes (all 8 values are defined):
  - 0 AND, 1 OR, 2 NAND, 3 NOR
  - 4 NOT A (B ignored), 5 NOT B (A ignored)
  - 6 XOR, 7 XNOR
  - Every opcode is applied bitwise across all `WIDTH` bits.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, select the winner by searching upward from `rr_ptr` with wrap-around.
  - `req_ready[winner]` = 1 combinationally, and only for the winner.
  - The handshake completes in that cycle. Latch op, a, b and id, then go to EXEC.
  - Update `rr_ptr` to (winner+1) mod NREQ.
  - With no request, stay in IDLE with all `req_ready` = 0.
- EXEC: the latched operands drive the logic unit. Register its output into `rsp_data`, register the id into `rsp_id`, set `rsp_valid` = 1, go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_valid && rsp_ready`.
  - On that edge, clear `rsp_valid` and go to IDLE.
  - `req_ready` is 0 for all requesters.
- `req_ready` is 0 in EXEC and RESP, regardless of `req_valid`.
- Requesters hold `req_valid` and their payload until accepted. A request deasserted before acceptance is simply not considered.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait and remain eligible.
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `busy` 0, latched operands 0.
- Reset mid-operation (EXEC or RESP): the transaction is discarded with no response. After reset release, arbitration restarts from requester 0.

## Timing
- A request accepted in cycle T gives `rsp_valid` = 1 in cycle T+2.
- If `rsp_ready` = 1 at T+2, the next grant can occur at T+3. Peak throughput is one operation per 3 cycles.
- Response backpressure of k cycles delays the next grant by k cycles.
- `req_ready` is a combinational function of state, `rr_ptr` and `req_valid`. No other output has a combinational path from an input.

## Structure
- Shared package `gate_op_pkg`:
  - 3-bit opcode type and the eight opcode constants
  - FSM state enum (IDLE, EXEC, RESP)
- Sub-module `gate_alu` is purely combinational:
  - inputs: op, a, b, each `WIDTH` wide except op
  - output: result
  - The top instantiates it once and feeds it from the latched operands.
- Round-robin search is a function or loop inside the top. It is not a separate module.

## Test plan
- Single request: requester 2 sends AND, a=8'hF0, b=8'hCC, accepted at T. Required: `rsp_valid` at T+2 with `rsp_data`=8'hC0 and `rsp_id`=2.
- Opcode sweep with a=8'hF0, b=8'hCC, opcodes 0..7 in turn. Required `rsp_data` in order: C0, FC, 3F, 03, 0F, 33, 3C, C3.
- Contention: all four `req_valid` held high from reset. Required grant order 0,1,2,3,0,1, one grant every 3 cycles with `rsp_ready` tied high.
- Pointer wrap: `rr_ptr`=3 with requesters 1 and 3 valid. Required: 3 granted first, then 1.
- Backpressure: `rsp_ready` held low 5 cycles in RESP. Required: `rsp_valid`, `rsp_data` and `rsp_id` stable, all `req_ready` 0. The next grant occurs in the cycle after the accepting edge.
- Reset in EXEC: assert `rst` for 1 cycle. Required: `rsp_valid` never rises for the aborted op, state IDLE, and the next grant comes from the lowest-indexed valid requester.
